magma_round_ctrl: RTL

//  Sequencer that runs one full 32-round Magma (GOST R 34.12-2015, 64-bit block) encryption or decryption.
//  It time-shares the external 1-stage round core, which computes result = rotl11(S(text_sum)) ^ op3 per 32-bit lane.
//  The controller owns the block/key registers, the modular key add and the key schedule. It also provides valid/ready handshakes

---
 rtl/magma_round_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/magma_round_ctrl.sv
// magma_round_ctrl
//   Sequences one full 32-round Magma (64-bit block) encryption or decryption.
//   It shares one external single-stage round core that computes
//   rotl11(S(text_sum)) ^ op3 on each 32-bit lane. This controller holds the
//   block halves, the key and the mode, forms the modular key add, walks the
//   key schedule and handles the upstream and downstream valid/ready handshakes.
//
// Parameters
//   LANE           round-core lane used: 0 = bits [31:0], 1 = bits [63:32]
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   flush          synchronous abort, discards the block in flight
//   in_valid/in_ready, in_mode (0 enc, 1 dec), in_key[255:0], in_data[63:0]
//   out_valid/out_ready, out_data[63:0]
//   busy           controller not idle
//   core_enable    round-core capture strobe
//   core_text_sum  round-core S-box input (a0 + K(round) on LANE)
//   core_op3       round-core XOR operand (a1 on LANE)
//   core_result    round-core output, valid the cycle after core_enable
//
// state | meaning
// IDLE  | ready for a new block
// ISSUE | present a0 + K(round) and a1 to the round core
// WAIT  | round-core result available, update the block halves
// DONE  | result held on out_data until out_ready
module magma_round_ctrl #(
  parameter int unsigned LANE = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [255:0] in_key,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy,
  output logic         core_enable,
  output logic [63:0]  core_text_sum,
  output logic [63:0]  core_op3,
  input  logic [63:0]  core_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       round_q, round_d;
  logic [31:0]      a1_q, a1_d;
  logic [31:0]      a0_q, a0_d;
  // key_q[7] holds K0 (in_key[255:224]) down to key_q[0] holding K7.
  logic [7:0][31:0] key_q, key_d;
  logic             mode_q, mode_d;

  logic             reverse;
  logic [2:0]       key_sel;
  logic [31:0]      round_key;
  logic [31:0]      text_sum;
  logic [31:0]      lane_result;
  logic             unused_lane;

  // Encrypt walks K0..K7 three times then K7..K0; decrypt walks K0..K7 once
  // then K7..K0 three times.
  assign reverse = mode_q ? (round_q >= 5'd8) : (round_q >= 5'd24);

  // Ki sits at key_q[7-i], and 7-i in three bits is ~i, so the forward order
  // uses the inverted round bits and the reversed order uses them directly.
  assign key_sel   = reverse ? round_q[2:0] : ~round_q[2:0];
  assign round_key = key_q[key_sel];
  assign text_sum  = a0_q + round_key;

  assign lane_result = core_result[LANE*32 +: 32];
  assign unused_lane = ^core_result[(1-LANE)*32 +: 32];

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    a1_d          = a1_q;
    a0_d          = a0_q;
    key_d         = key_q;
    mode_d        = mode_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    core_enable   = 1'b0;
    core_text_sum = '0;
    core_op3      = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a1_d    = in_data[63:32];
          a0_d    = in_data[31:0];
          key_d   = in_key;
          mode_d  = in_mode;
          round_d = 5'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        core_enable                    = 1'b1;
        core_text_sum[LANE*32 +: 32]   = text_sum;
        core_op3[LANE*32 +: 32]        = a1_q;
        state_d                        = WAIT;
      end
      WAIT: begin
        if (round_q == 5'd31) begin
          // Last round keeps the halves in place instead of swapping.
          a1_d    = lane_result;
          state_d = DONE;
        end else begin
          a1_d    = a0_q;
          a0_d    = lane_result;
          round_d = round_q + 5'd1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush overrides everything, including an accept or a held result.
    if (flush) begin
      state_d = IDLE;
      round_d = 5'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= 5'd0;
      a1_q    <= 32'd0;
      a0_q    <= 32'd0;
      key_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q != IDLE);
  // Only a finished block is ever visible; intermediate halves stay hidden.
  assign out_data = out_valid ? {a1_q, a0_q} : 64'd0;

endmodule
